// File: rtl/uart_pkg.sv
// uart_pkg: shared states and timing constants for the UART command path
package uart_pkg;
  typedef enum logic [1:0] {IDLE, COLLECT, HOLD} state_t;
  localparam int CLK_FREQ = 50_000_000;
  localparam int BAUD = 115_200;
  localparam int TIMEOUT_CYC = 60 * (CLK_FREQ / BAUD);
endpackage

// File: rtl/uart_timeout_cnt.sv
// uart_timeout_cnt: inter-byte timer, flags expiry on its terminal count
module uart_timeout_cnt #(
  parameter int TIMEOUT_CYC = uart_pkg::TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int TW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  logic [TW-1:0] timer;
  assign expired = en && timer == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) timer <= '0;
    else timer <= (clr || expired) ? '0 : en ? timer + 1'b1 : timer;
endmodule

// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: assembles receiver bytes into commands with an inter-byte timeout
module uart_cmd_seq
  import uart_pkg::*;
#(
  parameter int NUM_BYTES = 3,
  parameter int TIMEOUT_CYC = uart_pkg::TIMEOUT_CYC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_rdy,
  input  logic [7:0]             rx_data,
  output logic                   clr_rx_rdy,
  output logic [8*NUM_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  output logic                   timeout_err
);
  localparam int CW = $clog2(NUM_BYTES + 1);
  state_t state, state_nxt;
  logic [CW-1:0] byte_cnt;
  logic [8*NUM_BYTES-1:0] cmd_nxt;
  logic capture, last, expired;
  assign capture = rx_rdy && state != HOLD;
  assign clr_rx_rdy = capture;
  assign last = byte_cnt == CW'(NUM_BYTES - 1);
  generate
    if (NUM_BYTES == 1) begin : g_one
      assign cmd_nxt = rx_data;
    end else begin : g_shift
      assign cmd_nxt = {cmd[8*NUM_BYTES-9:0], rx_data};
    end
  endgenerate
  uart_timeout_cnt #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (capture || state != COLLECT),
    .en      (state == COLLECT),
    .expired (expired)
  );
  // a byte arriving on the terminal timer cycle takes priority over expiry
  always_comb
    state_nxt = capture ? (last ? HOLD : COLLECT)
              : (((state == COLLECT && expired) || (state == HOLD && clr_cmd_rdy)) ? IDLE : state);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state       <= IDLE;
      byte_cnt    <= '0;
      cmd         <= '0;
      cmd_rdy     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      byte_cnt    <= capture ? byte_cnt + 1'b1 : (state_nxt == IDLE ? '0 : byte_cnt);
      cmd         <= capture ? cmd_nxt : cmd;
      cmd_rdy     <= state_nxt == HOLD;
      timeout_err <= state == COLLECT && expired && !capture;
    end
endmodule
